// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared constants for the CP0 register block
// Contents: register index constants, SR/Cause bit positions, default PRId value.
package cp0_pkg;

  localparam logic [4:0] SEL_SR    = 5'd12;
  localparam logic [4:0] SEL_CAUSE = 5'd13;
  localparam logic [4:0] SEL_EPC   = 5'd14;
  localparam logic [4:0] SEL_PRID  = 5'd15;

  // SR: IM[15:10], EXL[1], IE[0]; Cause: IP[15:10]
  localparam int unsigned IM_HI   = 15;
  localparam int unsigned IM_LO   = 10;
  localparam int unsigned IP_HI   = 15;
  localparam int unsigned IP_LO   = 10;
  localparam int unsigned EXL_BIT = 1;
  localparam int unsigned IE_BIT  = 0;

  localparam logic [31:0] PRID_DEFAULT = 32'h0001_8000;

endpackage

// File: rtl/cp0_if.sv
// rtl/cp0_if.sv - CP0 register/interrupt bus
// Signals: Wen, EXLSet, EXLClr, pc[29:0], DIn[31:0], HWInt[5:0], sel[4:0] (to CP0);
//          IntReq, epc[29:0], DOut[31:0] (from CP0).
// Modports: master (processor side), slave (CP0 side).
interface cp0_if;

  logic        Wen;
  logic        EXLSet;
  logic        EXLClr;
  logic [29:0] pc;
  logic [31:0] DIn;
  logic [5:0]  HWInt;
  logic [4:0]  sel;
  logic        IntReq;
  logic [29:0] epc;
  logic [31:0] DOut;

  modport master (
    output Wen, EXLSet, EXLClr, pc, DIn, HWInt, sel,
    input  IntReq, epc, DOut
  );

  modport slave (
    input  Wen, EXLSet, EXLClr, pc, DIn, HWInt, sel,
    output IntReq, epc, DOut
  );

endinterface

// File: rtl/cp0.sv
// rtl/cp0.sv - CP0 status/cause/EPC/PRId registers with interrupt request
// Ports: clk (rising-edge clock), rst (synchronous active-low reset),
//        bus (cp0_if.slave: MTC0 write, interrupt entry/return strobes, MFC0 read, IntReq).
// Parameter: PRID_VALUE - value read from the processor-ID register.
// Optional feature: CP0_PRID_EN - when defined, sel=15 reads PRID_VALUE; otherwise 0.
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VALUE = PRID_DEFAULT
) (
  input  logic   clk,
  input  logic   rst,
  cp0_if.slave   bus
);

`ifdef CP0_PRID_EN
  localparam logic PRID_EN = 1'b1;
`else
  localparam logic PRID_EN = 1'b0;
`endif

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic [5:0]  ip;
  logic [29:0] epc_q;

  logic wr_sr;
  logic wr_epc;

  assign wr_sr  = bus.Wen && (bus.sel == SEL_SR);
  assign wr_epc = bus.Wen && (bus.sel == SEL_EPC);

  always_ff @(posedge clk) begin
    if (!rst) begin
      im    <= '0;
      exl   <= 1'b0;
      ie    <= 1'b0;
      ip    <= '0;
      epc_q <= '0;
    end else begin
      ip <= bus.HWInt;

      // IM/IE follow the write even when an interrupt entry lands in the same cycle
      if (wr_sr) begin
        im <= bus.DIn[IM_HI:IM_LO];
        ie <= bus.DIn[IE_BIT];
      end

      // EXL: entry beats return beats software write
      if (bus.EXLSet) begin
        exl <= 1'b1;
      end else if (bus.EXLClr) begin
        exl <= 1'b0;
      end else if (wr_sr) begin
        exl <= bus.DIn[EXL_BIT];
      end

      if (bus.EXLSet) begin
        epc_q <= bus.pc;
      end else if (wr_epc) begin
        epc_q <= bus.DIn[31:2];
      end
    end
  end

  // Live HWInt, not latched IP, so a line masks/unmasks without a cycle of delay
  assign bus.IntReq = (|(bus.HWInt & im)) & ie & ~exl;
  assign bus.epc    = epc_q;

  always_comb begin
    bus.DOut = 32'h0;
    case (bus.sel)
      SEL_SR:    bus.DOut = {16'h0, im, 8'h0, exl, ie};
      SEL_CAUSE: bus.DOut = {16'h0, ip, 10'h0};
      SEL_EPC:   bus.DOut = {epc_q, 2'b00};
      SEL_PRID:  bus.DOut = PRID_EN ? PRID_VALUE : 32'h0;
      default:   bus.DOut = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// tb/tb_cp0.sv - self-checking bench for cp0 (scoreboard of expected values)
// Ports exercised: all cp0_if signals plus clk/rst; CP0_PRID_EN selects PRId expectation.
module tb_cp0;

  logic clk;
  logic rst;

  cp0_if bus ();

  cp0 #(.PRID_VALUE(32'h0001_8000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] sb [$];
  logic [31:0] expv;
  logic [31:0] got;

`ifdef CP0_PRID_EN
  localparam logic [31:0] EXP_PRID = 32'h0001_8000;
`else
  localparam logic [31:0] EXP_PRID = 32'h0;
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.Wen    = 1'b0;
    bus.EXLSet = 1'b0;
    bus.EXLClr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    idle();
    bus.pc    = 30'h3FFF_FFFF;
    bus.DIn   = 32'hFFFF_FFFF;
    bus.HWInt = 6'h3F;
    bus.sel   = 5'd0;
    // strobes asserted during reset must be ignored
    bus.Wen = 1'b1; bus.sel = 5'd12; bus.EXLSet = 1'b1;
    tick();
    idle();
    sb.push_back(32'h0); sb.push_back(32'h0); sb.push_back(32'h0);
    sb.push_back(32'h0); sb.push_back(32'h0);
    for (int s = 12; s <= 14; s++) begin
      bus.sel = s[4:0];
      #1;
      got = bus.DOut; expv = sb.pop_front();
      checks++;
      if (got !== expv) begin
        $display("FAIL reset_dout_sel%0d got=%h exp=%h", s, got, expv);
        failures++;
      end
    end
    got = {31'h0, bus.IntReq}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL reset_intreq got=%h exp=%h", got, expv);
      failures++;
    end
    got = {2'b0, bus.epc}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL reset_epc got=%h exp=%h", got, expv);
      failures++;
    end
    rst = 1'b1;
  endtask

  task automatic test_enable();
    logic [5:0] pat [3];
    logic       req [3];
    pat[0] = 6'b000000; req[0] = 1'b0;
    pat[1] = 6'b000001; req[1] = 1'b1;
    pat[2] = 6'b000010; req[2] = 1'b0;
    bus.HWInt = 6'h0;
    bus.Wen = 1'b1; bus.sel = 5'd12; bus.DIn = 32'h0000_0401;
    tick();
    idle();
    for (int i = 0; i < 3; i++) sb.push_back({31'h0, req[i]});
    for (int i = 0; i < 3; i++) begin
      bus.HWInt = pat[i];
      #1;
      got = {31'h0, bus.IntReq}; expv = sb.pop_front();
      checks++;
      if (got !== expv) begin
        $display("FAIL enable_intreq_%0d got=%h exp=%h", i, got, expv);
        failures++;
      end
    end
    bus.HWInt = 6'b000001;
    #1;
  endtask

  task automatic test_entry();
    bus.pc = 30'h0000_0C05; bus.EXLSet = 1'b1;
    tick();
    idle();
    sb.push_back(32'h0000_0C05);
    sb.push_back(32'h0000_3014);
    sb.push_back(32'h0000_0403);
    sb.push_back(32'h0);
    got = {2'b0, bus.epc}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL entry_epc got=%h exp=%h", got, expv);
      failures++;
    end
    bus.sel = 5'd14; #1;
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL entry_epc_read got=%h exp=%h", got, expv);
      failures++;
    end
    bus.sel = 5'd12; #1;
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL entry_sr got=%h exp=%h", got, expv);
      failures++;
    end
    got = {31'h0, bus.IntReq}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL entry_intreq got=%h exp=%h", got, expv);
      failures++;
    end
  endtask

  task automatic test_return();
    bus.EXLClr = 1'b1;
    tick();
    idle();
    sb.push_back(32'h0000_0401);
    sb.push_back(32'h1);
    sb.push_back(32'h0000_0C05);
    bus.sel = 5'd12; #1;
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL return_sr got=%h exp=%h", got, expv);
      failures++;
    end
    got = {31'h0, bus.IntReq}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL return_intreq got=%h exp=%h", got, expv);
      failures++;
    end
    got = {2'b0, bus.epc}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL return_epc_kept got=%h exp=%h", got, expv);
      failures++;
    end
  endtask

  task automatic test_cause_prid();
    bus.HWInt = 6'b101000;
    bus.sel = 5'd13;
    #1;
    sb.push_back(32'h0000_0400);   // IP still holds the previous HWInt=000001
    sb.push_back(32'h0000_A000);
    sb.push_back(EXP_PRID);
    sb.push_back(32'h0);
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL cause_latency got=%h exp=%h", got, expv);
      failures++;
    end
    tick();
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL cause_read got=%h exp=%h", got, expv);
      failures++;
    end
    bus.sel = 5'd15; #1;
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL prid_read got=%h exp=%h", got, expv);
      failures++;
    end
    bus.sel = 5'd3; #1;
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL unmapped_read got=%h exp=%h", got, expv);
      failures++;
    end
  endtask

  task automatic test_collision();
    // EXLSet beats an EPC write
    bus.EXLSet = 1'b1; bus.Wen = 1'b1; bus.sel = 5'd14;
    bus.DIn = 32'hFFFF_FFFC; bus.pc = 30'h10;
    tick();
    idle();
    sb.push_back(32'h10);
    got = {2'b0, bus.epc}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL collision_epc got=%h exp=%h", got, expv);
      failures++;
    end
    // Cause is not writable
    bus.Wen = 1'b1; bus.sel = 5'd13; bus.DIn = 32'hFFFF_FFFF;
    tick();
    idle();
    sb.push_back(32'h0000_A000);
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL collision_cause got=%h exp=%h", got, expv);
      failures++;
    end
    // EXLClr beats SR write for EXL, IM/IE still written
    bus.EXLClr = 1'b1; bus.Wen = 1'b1; bus.sel = 5'd12; bus.DIn = 32'h0000_8003;
    tick();
    idle();
    sb.push_back(32'h0000_8001);
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL clr_over_wen_sr got=%h exp=%h", got, expv);
      failures++;
    end
    // EXLSet beats SR write clearing EXL, IM/IE still written
    bus.EXLSet = 1'b1; bus.Wen = 1'b1; bus.sel = 5'd12; bus.DIn = 32'h0000_0400;
    bus.pc = 30'h0123_4567;
    tick();
    idle();
    sb.push_back(32'h0000_0402);
    sb.push_back(32'h0123_4567);
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL set_over_wen_sr got=%h exp=%h", got, expv);
      failures++;
    end
    got = {2'b0, bus.epc}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL set_over_wen_epc got=%h exp=%h", got, expv);
      failures++;
    end
    // Plain EPC write, then ignored write to PRId
    bus.Wen = 1'b1; bus.sel = 5'd14; bus.DIn = 32'h8000_0007;
    tick();
    bus.sel = 5'd15; bus.DIn = 32'h1234_5678;
    tick();
    idle();
    sb.push_back(32'h2000_0001);
    sb.push_back(EXP_PRID);
    got = {2'b0, bus.epc}; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL wen_epc got=%h exp=%h", got, expv);
      failures++;
    end
    got = bus.DOut; expv = sb.pop_front();
    checks++;
    if (got !== expv) begin
      $display("FAIL wen_prid_ignored got=%h exp=%h", got, expv);
      failures++;
    end
  endtask

  initial begin
    rst = 1'b0;
    idle();
    bus.pc = '0; bus.DIn = '0; bus.HWInt = '0; bus.sel = '0;
    test_reset();
    test_enable();
    test_entry();
    test_return();
    test_cause_prid();
    test_collision();
    checks++;
    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
      failures++;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 Parameter PRID_VALUE, default 32'h0001_8000, value returned by the processor-ID register.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 Wen  input  1  write strobe for the register selected by sel (MTC0).
REQ-005 EXLSet  input  1  interrupt-entry strobe: save epc, set EXL.
REQ-006 EXLClr  input  1  interrupt-return strobe (ERET): clear EXL.
REQ-007 pc  input  30  word address [31:2] of the current instruction, saved on entry.
REQ-008 DIn  input  32  write data for MTC0.
REQ-009 HWInt  input  6  hardware interrupt lines [7:2], level-sensitive.
REQ-010 sel  input  5  CP0 register index (instr[20:16] for MTC0/MFC0).
REQ-011 IntReq  output  1  interrupt request to control FSM.
REQ-012 epc  output  30  EPC[31:2], used as the ERET target.
REQ-013 DOut  output  32  read data for MFC0, combinational from sel.

Function
REQ-014 Register map: 12 = SR, 13 = Cause, 14 = EPC, 15 = PRId; every other index reads 32'h0 and ignores writes.
REQ-015 SR layout: IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-016 Cause layout: IP[15:10]; all other bits read 0; IP register loads HWInt every cycle when not in reset.
REQ-017 EPC layout: bits [31:2] stored; bits [1:0] read 0.
REQ-018 IntReq = (|(HWInt & IM)) & IE & ~EXL, combinational; uses live HWInt, not latched IP.
REQ-019 Wen with sel=12 loads IM <= DIn[15:10], EXL <= DIn[1], IE <= DIn[0] at the clock edge.
REQ-020 Wen with sel=14 loads EPC <= DIn[31:2]; Wen with sel=13 or 15 has no effect.
REQ-021 EXLSet loads EPC <= pc and EXL <= 1 at the clock edge.
REQ-022 EXLClr sets EXL <= 0 at the clock edge; EPC unchanged.
REQ-023 Priority when asserted in the same cycle: EXLSet over EXLClr over Wen for EXL; EXLSet over Wen for EPC; IM/IE from Wen still apply when EXLSet is set.
REQ-024 Writes are visible on DOut/IntReq/epc in the cycle after the edge (one-cycle latency); no read-during-write bypass.

Reset
REQ-025 On a clock edge with rst=0: IM=0, EXL=0, IE=0, IP=0, EPC=0; rst overrides every strobe.
REQ-026 IntReq is 0 during and immediately after reset, because IE=0.

Configuration
REQ-027 Macro CP0_PRID_EN: when defined, sel=15 reads PRID_VALUE; when undefined, sel=15 reads 32'h0 like an unmapped index.

Structure
REQ-028 Shared package cp0_pkg holds the register index constants (12..15), the SR/Cause bit-position constants, and the default PRId value.
REQ-029 No sub-module is required; the read mux and IntReq logic stay inline in cp0.

Verification
REQ-030 Reset: rst=0 for 1 edge -> DOut=0 for sel 12/13/14; IntReq=0 with HWInt=6'h3F.
REQ-031 Enable and interrupt: Wen, sel=12, DIn=32'h0000_0401 (IM[10], IE) -> next cycle IntReq=0 with HWInt=0; HWInt=6'b000001 -> IntReq=1; HWInt=6'b000010 -> IntReq=0.
REQ-032 Entry: pc=30'h0000_0C05, EXLSet=1 -> epc=30'h0000_0C05, DOut(sel=14)=32'h0000_3014, SR reads 32'h0000_0403, IntReq=0 while HWInt stays asserted.
REQ-033 Return: EXLClr=1 -> SR reads 32'h0000_0401; IntReq returns to 1 while HWInt[2] is still high.
REQ-034 Cause/PRId: HWInt=6'b101000 -> sel=13 reads 32'h0000_A000 one cycle later; sel=15 reads 32'h0001_8000 with CP0_PRID_EN defined and 32'h0 without it.
REQ-035 Collision: EXLSet with Wen, sel=14, DIn=32'hFFFF_FFFC, pc=30'h10 -> epc=30'h10; Wen with sel=13 leaves Cause unchanged.
